// File: rtl/opp_pkg.sv
// opp_pkg -- shared constants for the output preprocessor.
//   OPP_W_CHAN / OPP_W_SEL / OPP_N_CHAN : default channel width, index width, channel count
//   OPP_SMIN / OPP_SMAX                 : signed limits at the default channel width
//   OPP_UMAX                            : all-ones unsigned value at the default width
package opp_pkg;

    localparam int OPP_W_CHAN = 16;
    localparam int OPP_W_SEL  = 4;
    localparam int OPP_N_CHAN = 8;

    localparam logic signed [OPP_W_CHAN-1:0] OPP_SMIN = {1'b1, {(OPP_W_CHAN-1){1'b0}}};
    localparam logic signed [OPP_W_CHAN-1:0] OPP_SMAX = {1'b0, {(OPP_W_CHAN-1){1'b1}}};
    localparam logic        [OPP_W_CHAN-1:0] OPP_UMAX = '1;

endpackage

// File: rtl/opp_clamp.sv
// opp_clamp -- combinational saturation of a widened sum into [min, max].
//   sum_i : W_CHAN+1 bit two's complement sum (sample + offset, cannot overflow)
//   min_i : signed lower limit
//   max_i : signed upper limit
//   res_o : saturated W_CHAN bit result; an inverted window (min > max) yields min
module opp_clamp
    import opp_pkg::*;
#(
    parameter int W_CHAN = OPP_W_CHAN
) (
    input  logic [W_CHAN:0]   sum_i,
    input  logic [W_CHAN-1:0] min_i,
    input  logic [W_CHAN-1:0] max_i,
    output logic [W_CHAN-1:0] res_o
);

    logic signed [W_CHAN:0] s_x;
    logic signed [W_CHAN:0] lo_x;
    logic signed [W_CHAN:0] hi_x;

    always_comb begin
        s_x   = sum_i;
        lo_x  = {min_i[W_CHAN-1], min_i};
        hi_x  = {max_i[W_CHAN-1], max_i};
        res_o = sum_i[W_CHAN-1:0];
        // inverted window must be checked first, otherwise large sums would pick max
        if (lo_x > hi_x)      res_o = min_i;
        else if (s_x < lo_x)  res_o = min_i;
        else if (s_x > hi_x)  res_o = max_i;
    end

endmodule

// File: rtl/output_preprocessor.sv
// output_preprocessor -- round-robin per-channel offset / clamp (/ optional slew limit)
// ahead of a DAC controller, with a valid/ready output handshake.
//   clk_in, rst_n_in      : clock, synchronous active-low reset
//   data_packed_in        : N_CHAN samples, channel i at [i*W_CHAN +: W_CHAN]
//   param_chan_in         : channel addressed by a parameter write (>= N_CHAN ignored)
//   offset_in/min_in/max_in/slew_in, update_in : parameter write port
//   ready_in              : downstream ready
//   data_out/chan_out/valid_out : processed sample, its channel, valid
// Optional feature: define OUTPUT_PREPROCESSOR_SLEW_EN to add per-channel slew limiting
// relative to the last transferred sample of that channel.
//
// Pipeline: idx selects a channel; stage 1 registers sample+offset plus a snapshot of
// that channel's limits; stage 2 (combinational) clamps/slews into the output register.
// A single advance enable stalls everything while valid_out & !ready_in.
module output_preprocessor
    import opp_pkg::*;
#(
    parameter int W_CHAN = OPP_W_CHAN,
    parameter int W_SEL  = OPP_W_SEL,
    parameter int N_CHAN = OPP_N_CHAN
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [W_CHAN*N_CHAN-1:0] data_packed_in,
    input  logic [W_SEL-1:0]         param_chan_in,
    input  logic [W_CHAN-1:0]        offset_in,
    input  logic [W_CHAN-1:0]        min_in,
    input  logic [W_CHAN-1:0]        max_in,
    input  logic [W_CHAN-1:0]        slew_in,
    input  logic                     update_in,
    input  logic                     ready_in,
    output logic [W_CHAN-1:0]        data_out,
    output logic [W_SEL-1:0]         chan_out,
    output logic                     valid_out
);

    localparam logic [W_CHAN-1:0] SMIN = {1'b1, {(W_CHAN-1){1'b0}}};
    localparam logic [W_CHAN-1:0] SMAX = {1'b0, {(W_CHAN-1){1'b1}}};

    logic [N_CHAN-1:0][W_CHAN-1:0] samp;
    assign samp = data_packed_in;

    // per-channel parameters
    logic [N_CHAN-1:0][W_CHAN-1:0] off_q;
    logic [N_CHAN-1:0][W_CHAN-1:0] min_q;
    logic [N_CHAN-1:0][W_CHAN-1:0] max_q;

    // pipeline state; vld_pipe_q[0] = stage 1, vld_pipe_q[1] = output register
    logic [W_SEL-1:0]  idx_q;
    logic [1:0]        vld_pipe_q;
    logic [W_CHAN:0]   s1_sum_q;
    logic [W_CHAN-1:0] s1_min_q;
    logic [W_CHAN-1:0] s1_max_q;
    logic [W_SEL-1:0]  s1_chan_q;
    logic [W_CHAN-1:0] dout_q;
    logic [W_SEL-1:0]  cout_q;

    logic              adv;
    logic [W_CHAN-1:0] cur_samp, cur_off, cur_min, cur_max;
    logic [W_CHAN:0]   cur_sum;
    logic [W_CHAN-1:0] clamp_res;
    logic [W_CHAN-1:0] s2_res;

    assign adv = ~vld_pipe_q[1] | ready_in;

    // read the selected channel; loop compare avoids indexing with an oversized idx
    always_comb begin
        cur_samp = '0;
        cur_off  = '0;
        cur_min  = '0;
        cur_max  = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (idx_q == W_SEL'(c)) begin
                cur_samp = samp[c];
                cur_off  = off_q[c];
                cur_min  = min_q[c];
                cur_max  = max_q[c];
            end
        end
        cur_sum = {cur_samp[W_CHAN-1], cur_samp} + {cur_off[W_CHAN-1], cur_off};
    end

    // parameter storage; writes land on the edge after capture reads, so the channel
    // being captured on that edge still uses its old values
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < N_CHAN; c++) begin
                off_q[c] <= '0;
                min_q[c] <= SMIN;
                max_q[c] <= SMAX;
            end
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (update_in && param_chan_in == W_SEL'(c)) begin
                    off_q[c] <= offset_in;
                    min_q[c] <= min_in;
                    max_q[c] <= max_in;
                end
            end
        end
    end

    opp_clamp #(.W_CHAN(W_CHAN)) u_clamp (
        .sum_i (s1_sum_q),
        .min_i (s1_min_q),
        .max_i (s1_max_q),
        .res_o (clamp_res)
    );

`ifdef OUTPUT_PREPROCESSOR_SLEW_EN
    logic [N_CHAN-1:0][W_CHAN-1:0] slew_q;
    logic [N_CHAN-1:0][W_CHAN-1:0] last_q;
    logic [W_CHAN-1:0]             cur_slew;
    logic [W_CHAN-1:0]             s1_slew_q;
    logic [W_CHAN-1:0]             last_rd;
    logic [W_CHAN-1:0]             base;
    logic signed [W_CHAN+1:0]      base_x, slew_x, hi_x, lo_x, cl_x;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < N_CHAN; c++) begin
                slew_q[c] <= '1;
                last_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (update_in && param_chan_in == W_SEL'(c))
                    slew_q[c] <= slew_in;
                if (vld_pipe_q[1] && ready_in && cout_q == W_SEL'(c))
                    last_q[c] <= dout_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in)  s1_slew_q <= '0;
        else if (adv)   s1_slew_q <= cur_slew;
    end

    always_comb begin
        cur_slew = '0;
        last_rd  = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (idx_q == W_SEL'(c))     cur_slew = slew_q[c];
            if (s1_chan_q == W_SEL'(c)) last_rd  = last_q[c];
        end
        // a same-channel sample leaving the output register transfers on this very
        // edge (stage 2 only loads when the output advances), so use it as the base
        base = (vld_pipe_q[1] && cout_q == s1_chan_q) ? dout_q : last_rd;
        base_x = {{2{base[W_CHAN-1]}}, base};
        slew_x = {2'b00, s1_slew_q};
        cl_x   = {{2{clamp_res[W_CHAN-1]}}, clamp_res};
        hi_x   = base_x + slew_x;
        lo_x   = base_x - slew_x;
        if (hi_x > $signed({2'b00, SMAX})) hi_x = {2'b00, SMAX};
        if (lo_x < $signed({2'b11, SMIN})) lo_x = {2'b11, SMIN};
        s2_res = clamp_res;
        if (cl_x > hi_x)      s2_res = hi_x[W_CHAN-1:0];
        else if (cl_x < lo_x) s2_res = lo_x[W_CHAN-1:0];
    end
`else
    logic unused_slew;
    assign unused_slew = ^slew_in;
    assign s2_res      = clamp_res;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            idx_q      <= '0;
            vld_pipe_q <= '0;
            s1_sum_q   <= '0;
            s1_min_q   <= '0;
            s1_max_q   <= '0;
            s1_chan_q  <= '0;
            dout_q     <= '0;
            cout_q     <= '0;
        end else if (adv) begin
            idx_q      <= (idx_q == W_SEL'(N_CHAN-1)) ? '0 : idx_q + 1'b1;
            vld_pipe_q <= {vld_pipe_q[0], 1'b1};
            s1_sum_q   <= cur_sum;
            s1_min_q   <= cur_min;
            s1_max_q   <= cur_max;
            s1_chan_q  <= idx_q;
            dout_q     <= s2_res;
            cout_q     <= s1_chan_q;
        end
    end

    assign data_out  = dout_q;
    assign chan_out  = cout_q;
    assign valid_out = vld_pipe_q[1];

endmodule
